dec_scan_seq: RTL and testbench
===============================

Name: dec_scan_seq

Overview:
- Sequencer that sits directly upstream of the 4-to-16 decoder and drives its enable and select inputs.
- Steps through the enabled channels of a 16-bit mask in ascending order.
- For each channel, holds the decoder enabled for DWELL cycles, then holds it disabled for BLANK cycles (anti-ghosting gap).
- Supports single-pass and continuous scanning, abort, and a completion pulse. Typical use: LED row scan or keypad column strobe.

Parameters:
- DWELL, 8, cycles en is high per channel; legal range 1..255.
- BLANK, 2, cycles en is low after each channel; legal range 0..255, where 0 means no gap.
- CNT_W, 8, width of the dwell/blank counter; must hold max(DWELL, BLANK).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; has priority over start.
- continuous  input  1  sampled with start; 1 = wrap forever, 0 = single pass.
- ch_mask  input  16  bit k = 1 means channel k is scanned; latched at start and at each wrap.
- en  output  1  decoder enable.
- in0, in1, in2, in3  output  1 each  decoder select, channel number LSB..MSB.
- busy  output  1  high while in ACTIVE or GAP.
- done  output  1  one-cycle pulse at the end of a completed scan.

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE; en, in0..in3, busy and done all 0; counter 0; latched mask 0. Reset mid-scan takes effect the same edge, with no done pulse.
- All outputs are registered. in0..in3 = current channel number; they hold their value through GAP and IDLE.
- States and transitions:
  - IDLE: start=1 with stop=0 latches ch_mask and continuous.
    - If the mask is non-zero: go to ACTIVE with the lowest set bit as channel; the next cycle shows en=1, busy=1. Latency is start sampled at cycle N, en high at cycle N+1.
    - If the mask is zero: stay in IDLE and pulse done at cycle N+1.
  - ACTIVE: en=1 for exactly DWELL cycles, then go to GAP.
    - If BLANK=0, go straight to the next channel instead (en stays high; select changes).
  - GAP: en=0 for exactly BLANK cycles. Then advance to the next set bit above the current channel.
    - If none remain and continuous=0: go to IDLE with busy=0 and done=1 for one cycle.
    - If none remain and continuous=1: relatch ch_mask and restart at its lowest set bit. If the relatched mask is zero, go to IDLE with a done pulse.
- stop=1 in ACTIVE or GAP: the next cycle is IDLE with en=0 and busy=0; no done pulse. stop in IDLE has no effect.
- start while busy: ignored. Changes to ch_mask mid-pass: ignored until the next latch point.
- Channel 15 followed by a wrap to channel 0 is handled without any 5-bit overflow. The channel register is 4 bits and the next-channel search covers bits above the current channel only.
- A single set bit with continuous=1 repeats that channel forever, with a gap each pass.
- Counter: loads DWELL-1 or BLANK-1 on state entry, decrements, and the state transitions when it reaches 0.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, ACTIVE=2'd1, GAP=2'd2;
  - CH_W=4 and NUM_CH=16.
- One natural combinational sub-module, next_ch_find:
  - inputs: 16-bit mask and 4-bit current channel;
  - outputs: the lowest set bit strictly above the current channel, a found flag, and the lowest set bit overall (used for wrap and start).

Test Plan:
- Single pass, DWELL=3, BLANK=1, mask=16'h8005, start at cycle 0 -> channel 0 high cycles 1-3, gap at 4; channel 2 high cycles 5-7, gap at 8; channel 15 high cycles 9-11, gap at 12; done=1 and busy=0 at cycle 13 only.
- Empty mask: mask=16'h0000 with start -> en never rises, busy stays 0, done pulses one cycle later.
- Continuous, mask=16'h0003, BLANK=0 -> select alternates 0,1,0,1 with en held at 1 and each value lasting DWELL cycles. A mask change to 16'h0004 mid-pass takes effect only after channel 1 completes.
- Abort: stop asserted in the second dwell cycle of channel 2 -> en=0 and busy=0 the next cycle, no done, select holds 2. A subsequent start works normally.
- Reset mid-scan: rst_n low during ACTIVE -> next edge gives all outputs 0. Start together with stop in IDLE -> no scan begins.
- Start while busy: pulse start during a GAP -> ignored, and the sequence timing is unchanged against a golden model.

Source files
------------

// File: rtl/dec_scan_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_seq_pkg : shared state encoding and channel sizes for the scanner |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dec_scan_seq_pkg;

    localparam int CH_W   = 4;
    localparam int NUM_CH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    typedef logic [CH_W-1:0]   ch_t;
    typedef logic [NUM_CH-1:0] mask_t;

endpackage
`default_nettype wire

// File: rtl/dec_scan_seq_next_ch_find.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_seq_next_ch_find : next set bit above cur, plus lowest set bit    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dec_scan_seq_next_ch_find
    import dec_scan_seq_pkg::*;
(
    input  mask_t mask,
    input  ch_t   cur,
    output ch_t   next_ch,
    output logic  found,
    output ch_t   first_ch
);

    // Descending walk so the lowest qualifying bit is the last one written.
    always_comb begin
        next_ch  = '0;
        found    = 1'b0;
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = ch_t'(i);
                if (ch_t'(i) > cur) begin
                    next_ch = ch_t'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dec_scan_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dec_scan_seq : dwell/blank scan sequencer driving a 4-to-16 decoder        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dec_scan_seq
    import dec_scan_seq_pkg::*;
#(
    parameter int DWELL = 8,
    parameter int BLANK = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              en,
    output logic              in0,
    output logic              in1,
    output logic              in2,
    output logic              in3,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_t              ch_q, ch_d;
    mask_t            mask_q, mask_d;
    logic             cont_q, cont_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    ch_t  next_ch;
    logic next_found;
    ch_t  live_first;
    logic live_any;
    logic advance;

    ch_t  unused_first_latched;
    ch_t  unused_next_live;
    logic unused_found_live;

    // Search above the current channel in the latched mask.
    dec_scan_seq_next_ch_find u_find_next (
        .mask     (mask_q),
        .cur      (ch_q),
        .next_ch  (next_ch),
        .found    (next_found),
        .first_ch (unused_first_latched)
    );

    // Lowest channel of the live mask, used at start and at each wrap.
    dec_scan_seq_next_ch_find u_find_live (
        .mask     (ch_mask),
        .cur      (ch_q),
        .next_ch  (unused_next_live),
        .found    (unused_found_live),
        .first_ch (live_first)
    );

    assign live_any = |ch_mask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        advance = 1'b0;

        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        mask_d = ch_mask;
                        cont_d = continuous;
                        if (live_any) begin
                            state_d = ACTIVE;
                            ch_d    = live_first;
                            cnt_d   = DWELL_LD;
                            en_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cnt_q == '0) begin
                        if (BLANK == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = GAP;
                            en_d    = 1'b0;
                            cnt_d   = BLANK_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase

            if (advance) begin
                if (next_found) begin
                    state_d = ACTIVE;
                    ch_d    = next_ch;
                    cnt_d   = DWELL_LD;
                    en_d    = 1'b1;
                end else if (cont_q && live_any) begin
                    state_d = ACTIVE;
                    mask_d  = ch_mask;
                    ch_d    = live_first;
                    cnt_d   = DWELL_LD;
                    en_d    = 1'b1;
                end else begin
                    if (cont_q) begin
                        mask_d = ch_mask;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign en   = en_q;
    assign in0  = ch_q[0];
    assign in1  = ch_q[1];
    assign in2  = ch_q[2];
    assign in3  = ch_q[3];
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dec_scan_seq : two scanners (gap / no gap) checked against a pass model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dec_scan_seq;

    localparam int DW   = 3;
    localparam int BL_A = 1;
    localparam int BL_B = 0;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, continuous;
    logic [15:0] ch_mask;

    logic en_a, in0_a, in1_a, in2_a, in3_a, busy_a, done_a;
    logic en_b, in0_b, in1_b, in2_b, in3_b, busy_b, done_b;
    logic [6:0] vec_a, vec_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;

    // Reference model state: index 0 models the gapped DUT, 1 the gapless one.
    logic        m_busy[2], m_en[2], m_done[2], m_cont[2];
    logic [3:0]  m_ch[2];
    logic [15:0] m_mask[2];
    int          m_pos[2];

    always #5 clk = ~clk;

    dec_scan_seq #(.DWELL(DW), .BLANK(BL_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .ch_mask(ch_mask), .en(en_a), .in0(in0_a), .in1(in1_a), .in2(in2_a), .in3(in3_a),
        .busy(busy_a), .done(done_a)
    );

    dec_scan_seq #(.DWELL(DW), .BLANK(BL_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .ch_mask(ch_mask), .en(en_b), .in0(in0_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
        .busy(busy_b), .done(done_b)
    );

    assign vec_a = {en_a, in3_a, in2_a, in1_a, in0_a, busy_a, done_a};
    assign vec_b = {en_b, in3_b, in2_b, in1_b, in0_b, busy_b, done_b};

    function automatic logic [3:0] nth_bit(input logic [15:0] mk, input int n);
        int seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (mk[k]) begin
                if (seen == n) return 4'(k);
                seen++;
            end
        end
        return 4'd0;
    endfunction

    function automatic logic [6:0] exp_vec(input int m);
        return {m_en[m], m_ch[m], m_busy[m], m_done[m]};
    endfunction

    // A pass is popcount(mask) slots of DWELL enabled cycles then BLANK dark cycles.
    task automatic show(input int m);
        int p;
        p = DW + ((m == 0) ? BL_A : BL_B);
        m_ch[m]   = nth_bit(m_mask[m], m_pos[m] / p);
        m_en[m]   = (m_pos[m] % p) < DW;
        m_busy[m] = 1'b1;
        m_done[m] = 1'b0;
    endtask

    task automatic model_step(input int m);
        int p;
        p = DW + ((m == 0) ? BL_A : BL_B);
        if (!rst_n) begin
            m_busy[m] = 0; m_en[m] = 0; m_done[m] = 0; m_cont[m] = 0;
            m_ch[m] = 4'd0; m_mask[m] = 16'd0; m_pos[m] = 0;
        end else if (m_busy[m]) begin
            if (stop) begin
                m_busy[m] = 0; m_en[m] = 0; m_done[m] = 0;
            end else begin
                m_pos[m]++;
                if (m_pos[m] < $countones(m_mask[m]) * p) begin
                    show(m);
                end else if (m_cont[m] && ch_mask != 16'd0) begin
                    m_mask[m] = ch_mask;
                    m_pos[m]  = 0;
                    show(m);
                end else begin
                    if (m_cont[m]) m_mask[m] = ch_mask;
                    m_busy[m] = 0; m_en[m] = 0; m_done[m] = 1;
                end
            end
        end else begin
            m_done[m] = 1'b0;
            if (start && !stop) begin
                m_mask[m] = ch_mask;
                m_cont[m] = continuous;
                m_pos[m]  = 0;
                if (ch_mask != 16'd0) show(m);
                else m_done[m] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic begin_idle();
        rst_n = 0; start = 0; stop = 0; continuous = 0; ch_mask = 16'd0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; stop = 0; continuous = 0; ch_mask = 16'd0;
        tick();
        tick();
        chk_cnt++;
        if (vec_a !== 7'd0) begin
            fail_cnt++; $display("FAIL reset_a: got %b want %b", vec_a, 7'd0);
        end else pass_cnt++;
        chk_cnt++;
        if (vec_b !== 7'd0) begin
            fail_cnt++; $display("FAIL reset_b: got %b want %b", vec_b, 7'd0);
        end else pass_cnt++;
        rst_n = 1;
    endtask

    task automatic test_single_pass();
        logic       e_en, e_busy, e_done;
        logic [3:0] e_ch;
        begin_idle();
        ch_mask = 16'h8005; start = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start  = 0;
            e_en   = (c >= 1 && c <= 3) || (c >= 5 && c <= 7) || (c >= 9 && c <= 11);
            e_ch   = (c <= 4) ? 4'd0 : (c <= 8) ? 4'd2 : 4'd15;
            e_busy = (c <= 12);
            e_done = (c == 13);
            chk_cnt++;
            if (vec_a !== {e_en, e_ch, e_busy, e_done}) begin
                fail_cnt++;
                $display("FAIL single_pass_a cyc %0d: got %b want %b", c, vec_a, {e_en, e_ch, e_busy, e_done});
            end else pass_cnt++;
            chk_cnt++;
            if (vec_b !== exp_vec(1)) begin
                fail_cnt++;
                $display("FAIL single_pass_b cyc %0d: got %b want %b", c, vec_b, exp_vec(1));
            end else pass_cnt++;
        end
    endtask

    task automatic test_empty_mask();
        logic [6:0] e;
        begin_idle();
        ch_mask = 16'h0000; start = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 0;
            e = {5'd0, 1'b0, (c == 1)};
            chk_cnt++;
            if (vec_a !== e) begin
                fail_cnt++; $display("FAIL empty_mask_a cyc %0d: got %b want %b", c, vec_a, e);
            end else pass_cnt++;
            chk_cnt++;
            if (vec_b !== e) begin
                fail_cnt++; $display("FAIL empty_mask_b cyc %0d: got %b want %b", c, vec_b, e);
            end else pass_cnt++;
        end
    endtask

    task automatic test_continuous();
        logic [3:0] e_ch;
        begin_idle();
        ch_mask = 16'h0003; continuous = 1; start = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 0;
            if (c == 8) ch_mask = 16'h0004;
            e_ch = (c <= 3) ? 4'd0 : (c <= 6) ? 4'd1 : (c <= 9) ? 4'd0 : (c <= 12) ? 4'd1 : 4'd2;
            chk_cnt++;
            if (vec_b !== {1'b1, e_ch, 1'b1, 1'b0}) begin
                fail_cnt++;
                $display("FAIL continuous_b cyc %0d: got %b want %b", c, vec_b, {1'b1, e_ch, 1'b1, 1'b0});
            end else pass_cnt++;
            chk_cnt++;
            if (vec_a !== exp_vec(0)) begin
                fail_cnt++; $display("FAIL continuous_a cyc %0d: got %b want %b", c, vec_a, exp_vec(0));
            end else pass_cnt++;
        end
        stop = 1; continuous = 0;
        tick();
        stop = 0;
        chk_cnt++;
        if ({vec_a[6], vec_a[1:0], vec_b[6], vec_b[1:0]} !== 6'd0) begin
            fail_cnt++;
            $display("FAIL continuous_stop: got a=%b b=%b want en/busy/done all 0", vec_a, vec_b);
        end else pass_cnt++;
    endtask

    task automatic test_abort();
        begin_idle();
        ch_mask = 16'h0005; start = 1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 0;
            stop  = (c == 6);
            if (c == 7) begin
                chk_cnt++;
                if ({vec_a, vec_b} !== {1'b0, 4'd2, 2'b00, 1'b0, 4'd2, 2'b00}) begin
                    fail_cnt++;
                    $display("FAIL abort cyc 7: got a=%b b=%b want 0010000 both", vec_a, vec_b);
                end else pass_cnt++;
            end else begin
                chk_cnt++;
                if ({vec_a, vec_b} !== {exp_vec(0), exp_vec(1)}) begin
                    fail_cnt++;
                    $display("FAIL abort cyc %0d: got a=%b b=%b want a=%b b=%b",
                             c, vec_a, vec_b, exp_vec(0), exp_vec(1));
                end else pass_cnt++;
            end
        end
        ch_mask = 16'h0002; start = 1;
        tick();
        start = 0;
        chk_cnt++;
        if ({vec_a, vec_b} !== {1'b1, 4'd1, 2'b10, 1'b1, 4'd1, 2'b10}) begin
            fail_cnt++;
            $display("FAIL abort_restart: got a=%b b=%b want 1000110 both", vec_a, vec_b);
        end else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_cnt++;
            if ({vec_a, vec_b} !== {exp_vec(0), exp_vec(1)}) begin
                fail_cnt++;
                $display("FAIL abort_restart_run %0d: got a=%b b=%b want a=%b b=%b",
                         c, vec_a, vec_b, exp_vec(0), exp_vec(1));
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_scan();
        begin_idle();
        ch_mask = 16'hFFFF; start = 1;
        tick();
        start = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk_cnt++;
        if ({vec_a, vec_b} !== 14'd0) begin
            fail_cnt++; $display("FAIL reset_mid_scan: got a=%b b=%b want all 0", vec_a, vec_b);
        end else pass_cnt++;
        start = 1; stop = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_cnt++;
            if ({vec_a, vec_b} !== 14'd0) begin
                fail_cnt++;
                $display("FAIL start_with_stop %0d: got a=%b b=%b want all 0", c, vec_a, vec_b);
            end else pass_cnt++;
        end
        start = 0; stop = 0;
    endtask

    task automatic test_back_to_back();
        begin_idle();
        ch_mask = 16'h8005; start = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start   = (c == 4);
            ch_mask = (c == 4) ? 16'hFFFF : 16'h8005;
            chk_cnt++;
            if ({vec_a, vec_b} !== {exp_vec(0), exp_vec(1)}) begin
                fail_cnt++;
                $display("FAIL start_while_busy cyc %0d: got a=%b b=%b want a=%b b=%b",
                         c, vec_a, vec_b, exp_vec(0), exp_vec(1));
            end else pass_cnt++;
            if (c == 13) begin
                chk_cnt++;
                if (vec_a[1:0] !== 2'b01) begin
                    fail_cnt++; $display("FAIL start_while_busy_done: got busy/done %b want 01", vec_a[1:0]);
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        int sel;
        begin_idle();
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 399) != 0);
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 79) == 0);
            continuous = $urandom_range(0, 1) != 0;
            sel        = $urandom_range(0, 9);
            if (sel == 0)      ch_mask = 16'h0000;
            else if (sel < 3)  ch_mask = 16'h0001 << $urandom_range(0, 15);
            else if (sel < 7)  ch_mask = 16'($urandom & $urandom & $urandom);
            else               ch_mask = 16'($urandom);
            tick();
            chk_cnt++;
            if ({vec_a, vec_b} !== {exp_vec(0), exp_vec(1)}) begin
                fail_cnt++;
                if (fail_cnt <= 20)
                    $display("FAIL random cyc %0d: got a=%b b=%b want a=%b b=%b",
                             c, vec_a, vec_b, exp_vec(0), exp_vec(1));
            end else pass_cnt++;
        end
        rst_n = 1; start = 0; stop = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_en[m] = 0; m_done[m] = 0; m_cont[m] = 0;
            m_ch[m] = 4'd0; m_mask[m] = 16'd0; m_pos[m] = 0;
        end
        rst_n = 0; start = 0; stop = 0; continuous = 0; ch_mask = 16'd0;
        test_reset();
        test_single_pass();
        test_empty_mask();
        test_continuous();
        test_abort();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
